mem_arbiter: RTL and testbench

Two-port arbiter/sequencer for the 16x8 synchronous memory with its shared bidirectional data bus.
- Accepts independent read/write requests from two requesters (port 0 = instruction fetch, port 1 = data unit).
- Grants the memory round-robin and drives address_bus, mem_enable and read_write.
- Owns the tri-state driver on data_bus; captures read data and returns it to the winning port with a done pulse.
- Sits between the CPU control unit and the memory block; it is the only driver of the memory's control pins.

---
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester-side bundle for mem_arbiter: two independent request ports
// (port 0 = instruction fetch, port 1 = data unit).
interface mem_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              done0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              done1;
  logic [DATA_W-1:0] rdata1;

  // Requester side: issues requests, observes grant/completion.
  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  gnt0, done0, rdata0,
    input  gnt1, done1, rdata1
  );

  // Arbiter side.
  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output gnt0, done0, rdata0,
    output gnt1, done1, rdata1
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for a synchronous memory with a
// shared bidirectional data bus. Sole driver of the memory control pins and
// owner of the data_bus tri-state driver. Every output comes from a flop.
module mem_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  mem_arbiter_if.slave      req_if,
  output logic [ADDR_W-1:0] address_bus,
  output logic              mem_enable,
  output logic              read_write,
  inout  wire  [DATA_W-1:0] data_bus,
  output logic              busy
);

  localparam int CNT_W = $clog2(READ_LAT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              id_q, id_d;         // port that owns the current transaction
  logic              last_q, last_d;     // port served most recently
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;     // latched address, drives address_bus
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              me_q, me_d;
  logic              rw_q, rw_d;
  logic              drive_q, drive_d;   // arbiter owns data_bus
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              busy_q, busy_d;
  logic              pick1;

  // Next-state, latched-request and registered-output computation.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d  = state_q;
    id_d     = id_q;
    last_d   = last_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    // On a tie the port that was not served last wins.
    pick1    = req_if.req1 && (!req_if.req0 || !last_q);

    unique case (state_q)
      IDLE: begin
        if (req_if.req0 || req_if.req1) begin
          id_d    = pick1;
          we_d    = pick1 ? req_if.we1    : req_if.we0;
          addr_d  = pick1 ? req_if.addr1  : req_if.addr0;
          wdata_d = pick1 ? req_if.wdata1 : req_if.wdata0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(READ_LAT);
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          if (id_q) rdata1_d = data_bus;
          else      rdata0_d = data_bus;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        last_d  = id_q;
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the upcoming state so they are flop outputs
    // aligned with the state they belong to.
    me_d    = (state_d == ACCESS) || (state_d == WAIT);
    drive_d = (state_d == ACCESS) && we_d;
    rw_d    = !drive_d;
    gnt0_d  = (state_d != IDLE) && !id_d;
    gnt1_d  = (state_d != IDLE) &&  id_d;
    done0_d = (state_d == DONE) && !id_d;
    done1_d = (state_d == DONE) &&  id_d;
    busy_d  = (state_d != IDLE);
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      id_q     <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      me_q     <= 1'b0;
      rw_q     <= 1'b1;
      drive_q  <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      id_q     <= id_d;
      last_q   <= last_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      me_q     <= me_d;
      rw_q     <= rw_d;
      drive_q  <= drive_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      busy_q   <= busy_d;
    end
  end

  // The bus is driven only during the single ACCESS cycle of a write.
  assign data_bus      = drive_q ? wdata_q : {DATA_W{1'bz}};
  assign address_bus   = addr_q;
  assign mem_enable    = me_q;
  assign read_write    = rw_q;
  assign busy          = busy_q;
  assign req_if.gnt0   = gnt0_q;
  assign req_if.gnt1   = gnt1_q;
  assign req_if.done0  = done0_q;
  assign req_if.done1  = done1_q;
  assign req_if.rdata0 = rdata0_q;
  assign req_if.rdata1 = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 16x8 memory
// (one cycle read latency) and a completion scoreboard.
module tb_mem_arbiter;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 8;
  localparam int READ_LAT = 1;

  typedef struct {
    logic              port;
    logic              is_read;
    logic [DATA_W-1:0] data;
    int                due;     // clock edge at which done is first seen high
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] address_bus;
  logic              mem_enable;
  logic              read_write;
  logic              busy;
  wire  [DATA_W-1:0] data_bus;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   bus_err  = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  int   s;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rif ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_if      (rif),
    .address_bus (address_bus),
    .mem_enable  (mem_enable),
    .read_write  (read_write),
    .data_bus    (data_bus),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: writes on a write-enabled edge, read data valid on the
  // bus for the cycle after a read-enabled edge.
  logic [DATA_W-1:0] mem [16];
  logic              mem_drv;
  logic [DATA_W-1:0] mem_dq;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem_drv = 1'b0;
    mem_dq  = '0;
  end

  always @(posedge clk) begin
    if (mem_enable && !read_write) mem[address_bus] <= data_bus;
    mem_drv <= mem_enable && read_write;
    mem_dq  <= mem[address_bus];
  end

  assign data_bus = (mem_drv && !reset) ? mem_dq : {DATA_W{1'bz}};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Undriven bus: Z in a four-state simulator, zero in a two-state one.
  function automatic logic bus_free();
    return (data_bus === {DATA_W{1'bz}}) || (data_bus === {DATA_W{1'b0}});
  endfunction

  task automatic set_port(input logic port, input logic req, input logic we,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
    if (port) begin
      rif.req1 = req; rif.we1 = we; rif.addr1 = addr; rif.wdata1 = wd;
    end else begin
      rif.req0 = req; rif.we0 = we; rif.addr0 = addr; rif.wdata0 = wd;
    end
  endtask

  task automatic push_exp(input logic port, input logic we, input logic [DATA_W-1:0] rd,
                          input int sample_edge);
    exp_t e;
    e.port    = port;
    e.is_read = !we;
    e.data    = rd;
    e.due     = sample_edge + (we ? 2 : 2 + READ_LAT);
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 50), 32'd1);
  endtask

  // One isolated transaction, called on a negedge with the arbiter idle.
  task automatic xact(input logic port, input logic we, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rd);
    set_port(port, 1'b1, we, addr, wd);
    push_exp(port, we, rd, cyc + 1);
    @(negedge clk);
    set_port(port, 1'b0, we, addr, wd);
    wait_idle("xact");
  endtask

  // Completion scoreboard and bus-ownership monitor.
  always @(negedge clk) begin
    if (!reset && (rif.done0 === 1'b1 || rif.done1 === 1'b1)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {30'd0, rif.done1, rif.done0}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_port1", 32'(rif.done1), 32'(mon_e.port));
        check("done_port0", 32'(rif.done0), 32'(!mon_e.port));
        check("done_edge", cyc + 1, mon_e.due);
        if (mon_e.is_read)
          check("rdata", 32'(mon_e.port ? rif.rdata1 : rif.rdata0), 32'(mon_e.data));
      end
    end
    if (mem_drv && !reset && data_bus !== mem_dq) bus_err <= bus_err + 1;
    if (mem_enable && !read_write && mem_drv)     bus_err <= bus_err + 1;
  end

  initial begin
    reset = 1'b1;
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_mem_enable", 32'(mem_enable), 32'd0);
    check("rst_read_write", 32'(read_write), 32'd1);
    check("rst_address",    32'(address_bus), 32'd0);
    check("rst_gnt",        {30'd0, rif.gnt1, rif.gnt0}, 32'd0);
    check("rst_done",       {30'd0, rif.done1, rif.done0}, 32'd0);
    check("rst_rdata0",     32'(rif.rdata0), 32'd0);
    check("rst_rdata1",     32'(rif.rdata1), 32'd0);
    check("rst_bus_free",   32'(bus_free()), 32'd1);
    check("rst_busy",       32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Port 0 write 0x0F to address 5, cycle by cycle.
    set_port(1'b0, 1'b1, 1'b1, 4'd5, 8'h0F);
    push_exp(1'b0, 1'b1, 8'h00, cyc + 1);
    @(negedge clk);
    check("wr_acc_me",   32'(mem_enable), 32'd1);
    check("wr_acc_rw",   32'(read_write), 32'd0);
    check("wr_acc_addr", 32'(address_bus), 32'd5);
    check("wr_acc_data", 32'(data_bus), 32'h0F);
    check("wr_acc_gnt",  {30'd0, rif.gnt1, rif.gnt0}, 32'b01);
    check("wr_acc_busy", 32'(busy), 32'd1);
    set_port(1'b0, 1'b0, 1'b1, 4'd9, 8'hEE);
    @(negedge clk);
    check("wr_done_me",  32'(mem_enable), 32'd0);
    check("wr_done_rw",  32'(read_write), 32'd1);
    check("wr_done_bus", 32'(bus_free()), 32'd1);
    @(negedge clk);
    check("wr_idle_busy", 32'(busy), 32'd0);
    check("wr_idle_gnt",  32'(rif.gnt0), 32'd0);
    check("wr_mem5",      32'(mem[5]), 32'h0F);

    // Port 1 read of address 5; address change during ACCESS is ignored.
    set_port(1'b1, 1'b1, 1'b0, 4'd5, 8'h00);
    push_exp(1'b1, 1'b0, 8'h0F, cyc + 1);
    @(negedge clk);
    check("rd_acc_me",   32'(mem_enable), 32'd1);
    check("rd_acc_rw",   32'(read_write), 32'd1);
    check("rd_acc_addr", 32'(address_bus), 32'd5);
    check("rd_acc_bus",  32'(bus_free()), 32'd1);
    check("rd_acc_gnt",  {30'd0, rif.gnt1, rif.gnt0}, 32'b10);
    set_port(1'b1, 1'b0, 1'b0, 4'd7, 8'h00);
    @(negedge clk);
    check("rd_wait_me",   32'(mem_enable), 32'd1);
    check("rd_wait_rw",   32'(read_write), 32'd1);
    check("rd_wait_addr", 32'(address_bus), 32'd5);
    @(negedge clk);
    check("rd_rdata0_kept", 32'(rif.rdata0), 32'd0);
    check("rd_done_me",     32'(mem_enable), 32'd0);
    wait_idle("rd");

    // Continuous contention from reset release: grants 0,1,0,1.
    reset = 1'b1;
    set_port(1'b0, 1'b1, 1'b0, 4'd5, 8'h00);
    set_port(1'b1, 1'b1, 1'b0, 4'd5, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    s = cyc + 1;
    for (int i = 0; i < 4; i++) push_exp(1'(i % 2), 1'b0, 8'h0F, s + 4 * i);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("rr_busy", 32'(busy),     32'(i % 4 != 3));
      check("rr_gnt0", 32'(rif.gnt0), 32'(i % 4 != 3 && (i / 4) % 2 == 0));
      check("rr_gnt1", 32'(rif.gnt1), 32'(i % 4 != 3 && (i / 4) % 2 == 1));
      if (i == 12) begin
        set_port(1'b0, 1'b0, 1'b0, 4'd5, 8'h00);
        set_port(1'b1, 1'b0, 1'b0, 4'd5, 8'h00);
      end
    end
    wait_idle("rr");

    // Reset in the middle of WAIT discards the read.
    set_port(1'b1, 1'b1, 1'b0, 4'd5, 8'h00);
    @(negedge clk);
    set_port(1'b1, 1'b0, 1'b0, 4'd5, 8'h00);
    @(negedge clk);
    check("mid_wait_me", 32'(mem_enable), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_me",   32'(mem_enable), 32'd0);
    check("mid_rst_bus",  32'(bus_free()), 32'd1);
    check("mid_rst_gnt",  32'(rif.gnt1), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check("mid_rst_rdata1", 32'(rif.rdata1), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_done", {30'd0, rif.done1, rif.done0}, 32'd0);
    xact(1'b1, 1'b0, 4'd5, 8'h00, 8'h0F);

    // Port 1 back-to-back writes interleaved with port 0 reads.
    set_port(1'b0, 1'b1, 1'b0, 4'd5, 8'h00);
    set_port(1'b1, 1'b1, 1'b1, 4'd3, 8'hA5);
    s = cyc + 1;
    push_exp(1'b0, 1'b0, 8'h0F, s);
    push_exp(1'b1, 1'b1, 8'h00, s + 4);
    @(negedge clk);
    set_port(1'b0, 1'b0, 1'b0, 4'd5, 8'h00);
    repeat (4) @(negedge clk);
    set_port(1'b1, 1'b1, 1'b1, 4'd4, 8'h5A);
    set_port(1'b0, 1'b1, 1'b0, 4'd3, 8'h00);
    push_exp(1'b0, 1'b0, 8'hA5, s + 7);
    push_exp(1'b1, 1'b1, 8'h00, s + 11);
    repeat (3) @(negedge clk);
    set_port(1'b0, 1'b0, 1'b0, 4'd3, 8'h00);
    repeat (4) @(negedge clk);
    set_port(1'b1, 1'b0, 1'b1, 4'd4, 8'h5A);
    wait_idle("mix");
    check("mix_mem3", 32'(mem[3]), 32'hA5);
    check("mix_mem4", 32'(mem[4]), 32'h5A);
    xact(1'b0, 1'b0, 4'd4, 8'h00, 8'h5A);
    xact(1'b1, 1'b0, 4'd3, 8'h00, 8'hA5);

    check("bus_contention", 32'(bus_err), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
